// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA pixel/line counters with sync decode and frame-granular run/stop
module vga_timing_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int CLK_DIV         = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       busy,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       X_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_MAX    = 10'(V_TOTAL - 1);
  localparam logic             SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_ctrl: CLK_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [9:0]       x_q, y_q;
  logic [9:0]       x_d, y_d;
  logic             hsync_q, vsync_q, video_q, line_q, frame_q;
  logic             tick_c, frame_end_c, go_idle_c;

  function automatic logic h_sync_on(input logic [9:0] xv);
    return (int'(xv) >= H_ACTIVE + H_FP) && (int'(xv) < H_ACTIVE + H_FP + H_SYNC);
  endfunction

  function automatic logic v_sync_on(input logic [9:0] yv);
    return (int'(yv) >= V_ACTIVE + V_FP) && (int'(yv) < V_ACTIVE + V_FP + V_SYNC);
  endfunction

  function automatic logic active(input logic [9:0] xv, input logic [9:0] yv);
    return (int'(xv) < H_ACTIVE) && (int'(yv) < V_ACTIVE);
  endfunction

  // Next raster position; the decoded outputs are registered from these so they never lag x/y.
  always_comb begin
    tick_c = (state_q != S_IDLE) && (div_q == DIV_MAX);
    x_d    = (x_q == X_MAX) ? 10'd0 : x_q + 10'd1;
    y_d    = y_q;
    if (x_q == X_MAX) begin
      y_d = (y_q == Y_MAX) ? 10'd0 : y_q + 10'd1;
    end
    frame_end_c = tick_c && (x_q == X_MAX) && (y_q == Y_MAX);
    go_idle_c   = reset
                || ((state_q == S_IDLE) && !run)
                || (frame_end_c && ((state_q == S_DRAIN) || !run));
  end

  always_ff @(posedge clk) begin
    if (go_idle_c) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      state_q <= S_RUN;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= h_sync_on(10'd0) ^ SYNC_OFF;
      vsync_q <= v_sync_on(10'd0) ^ SYNC_OFF;
      video_q <= active(10'd0, 10'd0);
      line_q  <= 1'b1;
      frame_q <= 1'b1;
    end else begin
      // Stop requests only take effect at the frame boundary handled by go_idle_c.
      state_q <= run ? S_RUN : S_DRAIN;
      if (tick_c) begin
        div_q   <= '0;
        x_q     <= x_d;
        y_q     <= y_d;
        hsync_q <= h_sync_on(x_d) ^ SYNC_OFF;
        vsync_q <= v_sync_on(y_d) ^ SYNC_OFF;
        video_q <= active(x_d, y_d);
        line_q  <= (x_d == 10'd0);
        frame_q <= (x_d == 10'd0) && (y_d == 10'd0);
      end else begin
        div_q   <= div_q + DIV_W'(1);
        line_q  <= 1'b0;
        frame_q <= 1'b0;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign pix_tick    = tick_c;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule
